// File: rtl/bram_arb_pkg.sv
// Shared types for the dual-requester BRAM arbiter: controller states and requester id.
package bram_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    ARB  = 1'b1
  } arb_state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; pointer names the requester that wins a tie.
module rr_arb2
  import bram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (&req) begin
      grant = pointer ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Arbitrates two requesters onto one BRAM write port and one BRAM read port.
// Optional power-up clear sweep enabled by defining BRAM_ARB_INIT_CLEAR_EN.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter  int LINE_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 128,
  localparam int AW         = $clog2(DEPTH),
  localparam int MW         = LINE_WIDTH / DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [MW-1:0]         req0_wmask,
  input  logic [AW-1:0]         req0_addr,
  input  logic [LINE_WIDTH-1:0] req0_wline,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [MW-1:0]         req1_wmask,
  input  logic [AW-1:0]         req1_addr,
  input  logic [LINE_WIDTH-1:0] req1_wline,
  output logic                  resp0_valid,
  output logic [LINE_WIDTH-1:0] resp0_rline,
  output logic                  resp1_valid,
  output logic [LINE_WIDTH-1:0] resp1_rline,
  output logic                  bram_wen,
  output logic [MW-1:0]         bram_wmask,
  output logic [AW-1:0]         bram_waddr,
  output logic [LINE_WIDTH-1:0] bram_wline,
  output logic                  bram_ren,
  output logic [AW-1:0]         bram_raddr,
  input  logic [LINE_WIDTH-1:0] bram_rline
);

  logic       in_arb;
  logic [1:0] valid, we, want_w, want_r, grant_w, grant_r;
  req_id_t    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic       rd_own_vld_q, rd_own_vld_d;
  req_id_t    rd_own_q, rd_own_d;

`ifdef BRAM_ARB_INIT_CLEAR_EN
  arb_state_e    state_q, state_d;
  logic [AW-1:0] sweep_cnt_q, sweep_cnt_d;

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    if (state_q == INIT) begin
      sweep_cnt_d = sweep_cnt_q + AW'(1);
      if (sweep_cnt_q == AW'(DEPTH - 1)) begin
        state_d = ARB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  assign in_arb = (state_q == ARB);
`else
  assign in_arb = 1'b1;
`endif

  assign valid  = {req1_valid, req0_valid};
  assign we     = {req1_we, req0_we};
  // Nothing is wanted during reset or the sweep, so every grant and ready stays low.
  assign want_w = (in_arb && !rst) ? (valid & we)  : 2'b00;
  assign want_r = (in_arb && !rst) ? (valid & ~we) : 2'b00;

  rr_arb2 u_wr_arb (.req(want_w), .pointer(wr_ptr_q), .grant(grant_w));
  rr_arb2 u_rd_arb (.req(want_r), .pointer(rd_ptr_q), .grant(grant_r));

  assign req0_ready = grant_w[0] | grant_r[0];
  assign req1_ready = grant_w[1] | grant_r[1];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    // A tie won by requester 0 hands the next tie to requester 1, and vice versa.
    if (&want_w) wr_ptr_d = grant_w[0];
    if (&want_r) rd_ptr_d = grant_r[0];
    rd_own_vld_d = |grant_r;
    rd_own_d     = grant_r[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      rd_own_vld_q <= 1'b0;
      rd_own_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_own_vld_q <= rd_own_vld_d;
      rd_own_q     <= rd_own_d;
    end
  end

  always_comb begin
    bram_wen   = |grant_w;
    bram_wmask = grant_w[1] ? req1_wmask : req0_wmask;
    bram_waddr = grant_w[1] ? req1_addr  : req0_addr;
    bram_wline = grant_w[1] ? req1_wline : req0_wline;
`ifdef BRAM_ARB_INIT_CLEAR_EN
    if (!in_arb && !rst) begin
      bram_wen   = 1'b1;
      bram_wmask = '1;
      bram_waddr = sweep_cnt_q;
      bram_wline = '0;
    end
`endif
    bram_ren   = |grant_r;
    bram_raddr = grant_r[1] ? req1_addr : req0_addr;
  end

  assign resp0_valid = !rst && rd_own_vld_q && !rd_own_q;
  assign resp1_valid = !rst && rd_own_vld_q &&  rd_own_q;
  assign resp0_rline = bram_rline;
  assign resp1_rline = bram_rline;

endmodule

// File: tb/tb_bram_arbiter.sv
// Randomized and directed bench for bram_arbiter with a BRAM fixture and a reference model;
// follows BRAM_ARB_INIT_CLEAR_EN to pick sweep or no-sweep expectations.
module tb_bram_arbiter;

  localparam int LW = 64;
  localparam int DW = 32;
  localparam int DEPTH = 128;
  localparam int AW = 7;
  localparam int MW = 2;

  typedef struct packed {
    logic          v;
    logic          we;
    logic [MW-1:0] m;
    logic [AW-1:0] a;
    logic [LW-1:0] l;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req0_valid, req0_ready, req0_we, req1_valid, req1_ready, req1_we;
  logic [MW-1:0] req0_wmask, req1_wmask;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [LW-1:0] req0_wline, req1_wline;
  logic          resp0_valid, resp1_valid;
  logic [LW-1:0] resp0_rline, resp1_rline;
  logic          bram_wen, bram_ren;
  logic [MW-1:0] bram_wmask;
  logic [AW-1:0] bram_waddr, bram_raddr;
  logic [LW-1:0] bram_wline, bram_rline;

  bram_arbiter #(.LINE_WIDTH(LW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_wmask(req0_wmask), .req0_addr(req0_addr), .req0_wline(req0_wline),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_wmask(req1_wmask), .req1_addr(req1_addr), .req1_wline(req1_wline),
    .resp0_valid(resp0_valid), .resp0_rline(resp0_rline),
    .resp1_valid(resp1_valid), .resp1_rline(resp1_rline),
    .bram_wen(bram_wen), .bram_wmask(bram_wmask), .bram_waddr(bram_waddr),
    .bram_wline(bram_wline), .bram_ren(bram_ren), .bram_raddr(bram_raddr),
    .bram_rline(bram_rline)
  );

  function automatic logic [LW-1:0] merge(input logic [LW-1:0] old_l, input logic [LW-1:0] new_l,
                                          input logic [MW-1:0] mask);
    logic [LW-1:0] r;
    r = old_l;
    for (int g = 0; g < MW; g++) if (mask[g]) r[g*DW +: DW] = new_l[g*DW +: DW];
    return r;
  endfunction

  // BRAM fixture: one-cycle read latency with same-cycle write forwarding.
  logic [LW-1:0] bram_mem [DEPTH];
  always @(posedge clk) begin
    if (bram_wen) bram_mem[bram_waddr] <= merge(bram_mem[bram_waddr], bram_wline, bram_wmask);
    if (bram_ren) bram_rline <= merge(bram_mem[bram_raddr], bram_wline,
                                      (bram_wen && bram_waddr == bram_raddr) ? bram_wmask : '0);
  end

  // Reference model state
  logic [LW-1:0] ref_mem [DEPTH];
  int            wr_prio, rd_prio;
  bit            pend_vld;
  int            pend_owner;
  logic [LW-1:0] pend_data;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input bit v, input bit w, input int m, input int a, input logic [LW-1:0] l);
    req_t r;
    r.v = v; r.we = w; r.m = MW'(m); r.a = AW'(a); r.l = l;
    return r;
  endfunction

  function automatic req_t rnd_req();
    return mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 15)), {$urandom, $urandom});
  endfunction

  task automatic apply(input req_t r0, input req_t r1);
    req0_valid = r0.v; req0_we = r0.we; req0_wmask = r0.m; req0_addr = r0.a; req0_wline = r0.l;
    req1_valid = r1.v; req1_we = r1.we; req1_wmask = r1.m; req1_addr = r1.a; req1_wline = r1.l;
  endtask

  // One arbitration cycle: drive, compare against the model at negedge, advance the model.
  task automatic cycle_arb(input req_t r0, input req_t r1);
    int wwin, rwin;
    req_t ws, rs;
    @(posedge clk); #1;
    rst = 1'b0;
    apply(r0, r1);
    @(negedge clk);
    if (r0.v && r0.we && r1.v && r1.we) begin wwin = wr_prio; wr_prio = 1 - wr_prio; end
    else if (r0.v && r0.we) wwin = 0;
    else if (r1.v && r1.we) wwin = 1;
    else wwin = -1;
    if (r0.v && !r0.we && r1.v && !r1.we) begin rwin = rd_prio; rd_prio = 1 - rd_prio; end
    else if (r0.v && !r0.we) rwin = 0;
    else if (r1.v && !r1.we) rwin = 1;
    else rwin = -1;
    ws = (wwin == 1) ? r1 : r0;
    rs = (rwin == 1) ? r1 : r0;
    chk("ready0", 64'(req0_ready), 64'(wwin == 0 || rwin == 0));
    chk("ready1", 64'(req1_ready), 64'(wwin == 1 || rwin == 1));
    chk("bram_wen", 64'(bram_wen), 64'(wwin >= 0));
    if (wwin >= 0) begin
      chk("bram_waddr", 64'(bram_waddr), 64'(ws.a));
      chk("bram_wmask", 64'(bram_wmask), 64'(ws.m));
      chk("bram_wline", bram_wline, ws.l);
    end
    chk("bram_ren", 64'(bram_ren), 64'(rwin >= 0));
    if (rwin >= 0) chk("bram_raddr", 64'(bram_raddr), 64'(rs.a));
    chk("resp0_valid", 64'(resp0_valid), 64'(pend_vld && pend_owner == 0));
    chk("resp1_valid", 64'(resp1_valid), 64'(pend_vld && pend_owner == 1));
    if (pend_vld) chk("resp_rline", (pend_owner == 1) ? resp1_rline : resp0_rline, pend_data);
    if (wwin >= 0) ref_mem[ws.a] = merge(ref_mem[ws.a], ws.l, ws.m);
    pend_vld = (rwin >= 0);
    pend_owner = rwin;
    if (rwin >= 0) pend_data = ref_mem[rs.a];
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      apply(rnd_req(), rnd_req());
      @(negedge clk);
      chk("rst_ready0", 64'(req0_ready), 64'd0);
      chk("rst_ready1", 64'(req1_ready), 64'd0);
      chk("rst_wen", 64'(bram_wen), 64'd0);
      chk("rst_ren", 64'(bram_ren), 64'd0);
      chk("rst_resp0", 64'(resp0_valid), 64'd0);
      chk("rst_resp1", 64'(resp1_valid), 64'd0);
    end
    wr_prio = 0; rd_prio = 0; pend_vld = 1'b0;
  endtask

  // With the clear sweep: DEPTH cycles of zero writes, requesters held off.
  task automatic sweep_or_first();
`ifdef BRAM_ARB_INIT_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      apply(mk(1, i % 2, 3, i, 64'h55), mk(1, (i + 1) % 2, 3, i, 64'h66));
      @(negedge clk);
      chk("sweep_wen", 64'(bram_wen), 64'd1);
      chk("sweep_waddr", 64'(bram_waddr), 64'(i));
      chk("sweep_wmask", 64'(bram_wmask), 64'd3);
      chk("sweep_wline", bram_wline, 64'd0);
      chk("sweep_ren", 64'(bram_ren), 64'd0);
      chk("sweep_ready0", 64'(req0_ready), 64'd0);
      chk("sweep_ready1", 64'(req1_ready), 64'd0);
      chk("sweep_resp", 64'(resp0_valid | resp1_valid), 64'd0);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    cycle_arb(mk(1, 0, 0, 3, 0), mk(1, 1, 3, 4, 64'h77));
    chk("first_arb_ready0", 64'(req0_ready), 64'd1);
`else
    cycle_arb(mk(1, 0, 0, 3, 0), mk(0, 0, 0, 0, 0));
    chk("first_arb_ready0", 64'(req0_ready), 64'd1);
`endif
  endtask

  req_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0);
    rst = 1'b1;
    apply(idle, idle);
    for (int i = 0; i < DEPTH; i++) begin
`ifdef BRAM_ARB_INIT_CLEAR_EN
      bram_mem[i] = {$urandom, $urandom};
`else
      bram_mem[i] = '0;
`endif
      ref_mem[i] = '0;
    end

    do_reset(3);
    sweep_or_first();

    // Write then read back through the other requester
    cycle_arb(mk(1, 1, 3, 5, 64'hDEAD_BEEF_0123_4567), idle);
    cycle_arb(idle, mk(1, 0, 0, 5, 0));
    chk("wr_rd_ready1", 64'(req1_ready), 64'd1);
    cycle_arb(idle, idle);
    chk("wr_rd_resp1", 64'(resp1_valid), 64'd1);
    chk("wr_rd_resp0", 64'(resp0_valid), 64'd0);
    chk("wr_rd_data", resp1_rline, 64'hDEAD_BEEF_0123_4567);

    // Contested reads alternate starting with requester 0
    for (int k = 0; k < 4; k++) begin
      cycle_arb(mk(1, 0, 0, 5, 0), mk(1, 0, 0, 9, 0));
      chk("alt_ready0", 64'(req0_ready), 64'(k % 2 == 0));
      if (k > 0) chk("alt_resp0", 64'(resp0_valid), 64'((k - 1) % 2 == 0));
    end

    // Same-cycle masked write and read of one line
    cycle_arb(mk(1, 1, 1, 9, 64'h1111_1111_2222_2222), mk(1, 0, 0, 9, 0));
    chk("fwd_both_ready", 64'({req0_ready, req1_ready}), 64'd3);
    cycle_arb(idle, idle);
    chk("fwd_data", resp1_rline, 64'h0000_0000_2222_2222);

    for (int i = 0; i < 400; i++) cycle_arb(rnd_req(), rnd_req());

    // Reset right after a read accept drops the response and restarts the sweep
    cycle_arb(mk(1, 0, 0, 5, 0), idle);
    do_reset(1);
    sweep_or_first();
    for (int i = 0; i < 50; i++) cycle_arb(rnd_req(), rnd_req());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
